shift_sequencer: RTL
====================

# shift_sequencer

Controller that owns the shift-in port of the 8-bit LED shifter and shares it between two requesters: the manual path (debounced, edge-detected button pulses) and an automatic pattern loader that serialises an 8-bit pattern MSB-first into the shifter. It sits between the button edge detectors and the shifter. It drives the shifter's shift-0/shift-1 pulse inputs and makes sure at most one shift happens per cycle.

## Interface
- WIDTH, 8: pattern length, which is also the number of shift pulses per load.
- GAP_CYCLES, 4: idle cycles inserted between consecutive automatic pulses. Range 0..255.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- async_nreset  in  1  reset, asynchronous, active-low.
- man0_re  in  1  manual request to shift in a 0 (single-cycle pulse).
- man1_re  in  1  manual request to shift in a 1 (single-cycle pulse).
- load_req  in  1  start an automatic load (single-cycle pulse).
- load_pattern  in  WIDTH  pattern to load; sampled only in the cycle load_req is accepted.
- abort  in  1  cancel an automatic load in progress.
- shift0  out  1  to the shifter: shift in 0. Registered.
- shift1  out  1  to the shifter: shift in 1. Registered.
- busy  out  1  an automatic load owns the shifter.
- done  out  1  single-cycle pulse when a load completes normally.
- man_dropped  out  1  single-cycle pulse when a manual request is discarded.
- load_rejected  out  1  single-cycle pulse when load_req arrives while busy.

## Operation
- States:
  - IDLE: manual path owns the port.
  - SHIFT: emit one automatic pulse.
  - GAP: wait out GAP_CYCLES.
  - DONE: completion cycle.
- IDLE behaviour:
  - man0_re alone → shift0 the next cycle.
  - man1_re alone → shift1 the next cycle.
  - man0_re and man1_re together → no shift; man_dropped.
- IDLE + load_req:
  - Capture load_pattern into shift register pat; clear bit counter idx; go to SHIFT.
  - Any manual pulse in the same cycle is dropped (man_dropped).
- SHIFT:
  - Assert shift1 if pat[WIDTH-1] is 1, else shift0.
  - Shift pat left by one; increment idx.
  - If idx is now WIDTH → go to DONE.
  - Else if GAP_CYCLES = 0 → stay in SHIFT.
  - Else → go to GAP and load the gap counter with GAP_CYCLES-1.
- GAP: decrement the gap counter; at 0 → go to SHIFT.
- DONE: assert done; go to IDLE.
- While busy (SHIFT, GAP, DONE):
  - Every manual pulse → man_dropped.
  - Every load_req → load_rejected; the pattern is ignored.
- abort in any non-IDLE state → IDLE next cycle. No further pulses, no done. Already-shifted bits stay in the shifter.
- abort in IDLE has priority over load_req and manual pulses; those are silently ignored (no flags).
- shift0 and shift1 are never asserted in the same cycle.

## Timing
- Reset values: state IDLE; pat, idx and gap counter 0; every output 0.
- Manual latency: request in cycle t → pulse in cycle t+1.
- Automatic load accepted in cycle t:
  - busy = 1 from t+1.
  - Pulse k (k = 0..WIDTH-1) in cycle t+1+k·(GAP_CYCLES+1).
  - done in the cycle after the last pulse; busy = 0 in the cycle after done.
  - Defaults (WIDTH 8, GAP 4): pulses at t+1, t+6, …, t+36; done at t+37; busy low at t+38.
- abort sampled in cycle t → no pulse in t+1 or later; busy = 0 in t+1.
- A reset assertion mid-load returns everything to reset values immediately.
- A back-to-back load is possible: load_req in the cycle busy falls is accepted.

## Structure
- Shared package holds:
  - the state enum (IDLE, SHIFT, GAP, DONE);
  - default WIDTH and GAP_CYCLES;
  - a function computing the gap-counter width (clog2 of GAP_CYCLES+1, minimum 1).
- One natural sub-module: gap_timer. It is a loadable down-counter with load, enable and zero outputs, and is reused elsewhere for debounce spacing.
- All other logic is a single FSM with a registered output stage.

## Test plan
- Reset, then man1_re at t → shift1 = 1 only at t+1, and the shifter holds 0x01. Then man0_re → the shifter holds 0x02.
- load_req with pattern 0xA5 at t, GAP 4 →
  - pulse sequence 1,0,1,0,0,1,0,1 at t+1, t+6, …, t+36;
  - done at t+37; shifter = 0xA5.
- During a load, man0_re at t+3 and load_req at t+10 → man_dropped at t+4, load_rejected at t+11; pulse schedule unchanged; final value 0xA5.
- abort at t+12 during a load of 0xFF → exactly 3 shift1 pulses, no done, busy low at t+13, shifter = 0x07.
- man0_re and man1_re together in IDLE → no shift, man_dropped once.
- GAP_CYCLES = 0 with pattern 0x3C → pulses on 8 consecutive cycles, done at t+9.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer shared types and sizing helpers.
// State encoding, default geometry, gap-counter width.
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_GAP   = 4;

  function automatic int gap_cnt_w(input int gap);
    return (gap < 1) ? 1 : $clog2(gap + 1);
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between requesters,
// the sequencer and the LED shifter.
interface shift_sequencer_if
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             man0_re;
  logic             man1_re;
  logic             load_req;
  logic [WIDTH-1:0] load_pattern;
  logic             abort;
  logic             shift0;
  logic             shift1;
  logic             busy;
  logic             done;
  logic             man_dropped;
  logic             load_rejected;

  modport master (
    output man0_re, man1_re, load_req,
    output load_pattern, abort,
    input  shift0, shift1, busy, done,
    input  man_dropped, load_rejected
  );

  modport slave (
    input  man0_re, man1_re, load_req,
    input  load_pattern, abort,
    output shift0, shift1, busy, done,
    output man_dropped, load_rejected
  );

endinterface

// File: rtl/shift_sequencer_gap_timer.sv
// gap_timer: loadable down-counter that stops at zero.
// Shared with the debounce spacing logic.
module gap_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         async_nreset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // load wins over counting; counting saturates at zero
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: arbitrates the shifter's shift-in port
// between manual button pulses and an automatic pattern load.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int GAP_CYCLES = DEF_GAP
) (
  input logic             clk,
  input logic             async_nreset,
  shift_sequencer_if.slave bus
);

  localparam int GW = gap_cnt_w(GAP_CYCLES);
  localparam int IW = $clog2(WIDTH + 1);
  localparam int GL = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GW-1:0] GLOAD    = GW'(GL);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  state_e           state, state_d;
  logic [WIDTH-1:0] pat, pat_d;
  logic [IW-1:0]    idx, idx_d;
  logic             g_load, g_zero;
  logic             any_man;
  logic             shift0_d, shift1_d, busy_d;
  logic             done_d, drop_d, rej_d;

  assign any_man = bus.man0_re | bus.man1_re;

  gap_timer #(.W(GW)) u_gap (
    .clk          (clk),
    .async_nreset (async_nreset),
    .load         (g_load),
    .en           (state == ST_GAP),
    .load_val     (GLOAD),
    .zero         (g_zero)
  );

  // state, pattern shift register and bit counter
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state <= ST_IDLE;
      pat   <= '0;
      idx   <= '0;
    end else begin
      state <= state_d;
      pat   <= pat_d;
      idx   <= idx_d;
    end
  end

  // next state; abort from any busy state wins
  always_comb begin
    state_d = state;
    pat_d   = pat;
    idx_d   = idx;
    g_load  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!bus.abort && bus.load_req) begin
          pat_d   = bus.load_pattern;
          idx_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        pat_d = {pat[WIDTH-2:0], 1'b0};
        idx_d = idx + IW'(1);
        if (idx == IDX_LAST) begin
          state_d = ST_DONE;
        end else if (GAP_CYCLES == 0) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_GAP;
          g_load  = 1'b1;
        end
      end
      ST_GAP: begin
        if (g_zero) state_d = ST_SHIFT;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.abort && state != ST_IDLE) begin
      state_d = ST_IDLE;
      g_load  = 1'b0;
    end
  end

  // outputs for the next cycle, aligned with state_d
  always_comb begin
    shift0_d = 1'b0;
    shift1_d = 1'b0;
    drop_d   = 1'b0;
    rej_d    = 1'b0;
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    if (state == ST_IDLE) begin
      if (!bus.abort) begin
        if (bus.load_req) begin
          drop_d = any_man;
        end else begin
          drop_d   = bus.man0_re & bus.man1_re;
          shift0_d = bus.man0_re & ~bus.man1_re;
          shift1_d = bus.man1_re & ~bus.man0_re;
        end
      end
    end else begin
      drop_d = any_man;
      rej_d  = bus.load_req;
    end
    if (state_d == ST_SHIFT) begin
      shift1_d = pat_d[WIDTH-1];
      shift0_d = ~pat_d[WIDTH-1];
    end
  end

  // registered output stage
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      bus.shift0        <= 1'b0;
      bus.shift1        <= 1'b0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.man_dropped   <= 1'b0;
      bus.load_rejected <= 1'b0;
    end else begin
      bus.shift0        <= shift0_d;
      bus.shift1        <= shift1_d;
      bus.busy          <= busy_d;
      bus.done          <= done_d;
      bus.man_dropped   <= drop_d;
      bus.load_rejected <= rej_d;
    end
  end

endmodule
